instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the 12-bit CPU; drives the ALU/register-file stage with decoded fields opcode, addr1, addr2 and addr3.
- Holds a small writable instruction memory, a program counter and a 3-state controller.
- Presents one registered instruction per clk while running; halts on opcode 000.

Parameters:
- INSTR_W, 12, instruction width; field layout fixed at [11:9] opcode, [8:6] addr1, [5:3] addr2, [2:0] addr3.
- PC_W, 4, program-counter width.
- IMEM_DEPTH, 16, instruction-memory words; must equal 2**PC_W.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin or restart execution from address 0.
- stall  input  1  downstream hold request; freezes fetch.
- load_en  input  1  instruction-memory write enable.
- load_addr  input  PC_W  write address.
- load_data  input  INSTR_W  write data.
- opcode  output  3  registered instruction[11:9].
- addr1  output  3  registered instruction[8:6].
- addr2  output  3  registered instruction[5:3].
- addr3  output  3  registered instruction[2:0].
- instr_valid  output  1  fields carry a real instruction this cycle.
- pc  output  PC_W  address of the next word to fetch.
- halted  output  1  controller is in HALT.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous):
  - state=IDLE; pc=0; opcode, addr1, addr2 and addr3 = 0; instr_valid=0; halted=0.
  - Memory contents are not cleared and are retained across reset.
- States:
  - IDLE: start=1 -> FETCH. stall is ignored. instr_valid=0.
  - FETCH, stall=0, word=imem[pc]:
    - opcode!=000: the output register loads word; instr_valid<=1; pc<=pc+1.
    - opcode==000 (HALT word): the output register is unchanged; instr_valid<=0; pc is unchanged (it points at the halt word); state<=HALT; halted<=1.
  - FETCH, stall=1: pc, output fields and instr_valid all hold their values. A halt word is not consumed while stalled.
  - HALT: instr_valid=0; fields hold their last values. start=1 -> pc<=0, halted<=0, state<=FETCH.
- start while in FETCH is ignored.
- Latency: the word at address N appears on the outputs at the edge that advances pc to N+1. The first valid instruction appears 2 edges after start is sampled: edge 1 enters FETCH; edge 2 loads imem[0].
- Wrap-around: pc=IMEM_DEPTH-1 increments to 0 with no flag and keeps fetching.
- Memory write:
  - Performed synchronously when load_en=1 and state is IDLE or HALT. Ignored in FETCH.
  - A write and a start in the same cycle are both performed.
  - A read in a later cycle returns the newly written data; there is no same-cycle read-after-write.
- Reads are combinational from the array into the registered outputs; there is no extra pipeline stage.
- Reset mid-run immediately forces the reset values; execution resumes only on a new start.
- The downstream stage treats its inputs as don't-care when instr_valid=0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle -> outputs clear immediately (pc=0, instr_valid=0, halted=0). Pulse stall in IDLE -> no change.
- Straight-line program:
  - Load addr0..3 = 001010000001, 010011000001, 011100000001, 000000000000; pulse start.
  - Expect, on consecutive edges: opcode=001, addr1=2, addr2=0, addr3=1 with instr_valid=1; then 010/3/0/1; then 011/4/0/1.
  - Next edge: instr_valid=0, halted=1, pc=3.
- Stall: during the above program, hold stall high for 3 cycles after the second instruction -> opcode stays 010, pc stays 2, instr_valid stays 1. On release, 011 follows on the next edge.
- Wrap-around: fill all 16 words with 101111101110 (no halt) and start -> pc sequence ...,14,15,0,1 with instr_valid continuously 1.
- Restart and load gating:
  - In HALT, write addr0 = 111010001000 and pulse start -> first output opcode=111, addr1=2, addr2=1, addr3=0.
  - A load_en pulse issued during FETCH leaves memory unchanged (verify by read-back via a later run).
- Reset mid-run: drop rst_n while in FETCH at pc=5 -> outputs clear immediately. After rst_n rises, no fetch occurs until start, and memory contents are intact.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: writable instruction memory, program counter and IDLE/FETCH/HALT controller.
// Latency: imem[pc] is registered onto the field outputs at the edge that advances pc (1 edge).
// Backpressure: stall freezes pc, fields and instr_valid; a halt word is not consumed while stalled.
module instr_fetch_unit #(
  parameter int INSTR_W    = 12,
  parameter int PC_W       = 4,
  parameter int IMEM_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [2:0]         opcode,
  output logic [2:0]         addr1,
  output logic [2:0]         addr2,
  output logic [2:0]         addr3,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Instruction memory is deliberately outside the reset domain so a program
  // survives a reset and can be re-run with a new start.
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               mem_we;
  logic [INSTR_W-1:0] word;
  logic               word_is_halt;

  // Combinational read straight into the output register; no read pipeline.
  assign word         = imem[pc_q];
  assign word_is_halt = (word[INSTR_W-1 -: 3] == 3'b000);

  // Writes are only allowed while the controller is not fetching.
  assign mem_we = load_en && (state_q != FETCH);

  // Next-state, pc and output-register logic for the controller.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (!stall) begin
          if (!word_is_halt) begin
            instr_d = word;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_ONE;
          end else begin
            // pc stays on the halt word; last fields are kept for observation.
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (start) begin
          pc_d     = '0;
          halted_d = 1'b0;
          state_d  = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Controller and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Synchronous memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) imem[load_addr] <= load_data;
  end

  assign opcode      = instr_q[INSTR_W-1 -: 3];
  assign addr1       = instr_q[INSTR_W-4 -: 3];
  assign addr2       = instr_q[INSTR_W-7 -: 3];
  assign addr3       = instr_q[2:0];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic [2:0]  opcode;
  logic [2:0]  addr1;
  logic [2:0]  addr2;
  logic [2:0]  addr3;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Reference model: program as an array, a running flag and the visible outputs.
  logic [11:0] m_mem [16];
  bit          m_running;
  bit          m_halted;
  bit          m_valid;
  logic [11:0] m_word;
  int          m_pc;

  instr_fetch_unit #(.INSTR_W(12), .PC_W(4), .IMEM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .opcode(opcode), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_running = 0;
    m_halted  = 0;
    m_valid   = 0;
    m_word    = '0;
    m_pc      = 0;
  endtask

  // One clock edge of the architectural behaviour, given the inputs sampled there.
  task automatic m_edge(input logic st, input logic sl, input logic le,
                        input logic [3:0] la, input logic [11:0] ld);
    logic [11:0] w;
    bit wr;
    wr = le && !m_running;
    if (m_running) begin
      if (!sl) begin
        w = m_mem[m_pc];
        if (w[11:9] != 3'b000) begin
          m_word  = w;
          m_valid = 1;
          m_pc    = (m_pc + 1) % 16;
        end else begin
          m_valid   = 0;
          m_running = 0;
          m_halted  = 1;
        end
      end
    end else if (st) begin
      m_running = 1;
      m_halted  = 0;
      m_pc      = 0;
    end
    if (wr) m_mem[la] = ld;
  endtask

  task automatic check_model();
    chk("pc",          pc,          m_pc);
    chk("instr_valid", instr_valid, m_valid);
    chk("halted",      halted,      m_halted);
    chk("opcode",      opcode,      m_word[11:9]);
    chk("addr1",       addr1,       m_word[8:6]);
    chk("addr2",       addr2,       m_word[5:3]);
    chk("addr3",       addr3,       m_word[2:0]);
  endtask

  task automatic step(input logic st, input logic sl, input logic le,
                      input logic [3:0] la, input logic [11:0] ld);
    start = st; stall = sl; load_en = le; load_addr = la; load_data = ld;
    @(posedge clk);
    #1;
    m_edge(st, sl, le, la, ld);
    check_model();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
  endtask

  initial begin
    logic [11:0] prog [4];
    logic [11:0] rd;
    prog[0] = 12'b001010000001;
    prog[1] = 12'b010011000001;
    prog[2] = 12'b011100000001;
    prog[3] = 12'b000000000000;

    start = 0; stall = 0; load_en = 0; load_addr = '0; load_data = '0;
    rst_n = 1'b1;
    m_reset();

    // Asynchronous reset, checked between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_model();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // stall has no effect in IDLE.
    step(1'b0, 1'b1, 1'b0, 4'd0, 12'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 12'd0);
    chk("idle_stall_pc", pc, 0);

    // Straight-line program with a 3-cycle stall after the second instruction.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i[3:0], prog[i]);
    step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
    chk("enter_fetch_valid", instr_valid, 0);
    idle_step();
    chk("i0_op", opcode, 3'b001); chk("i0_a1", addr1, 3'd2);
    chk("i0_a2", addr2, 3'd0);    chk("i0_a3", addr3, 3'd1);
    chk("i0_vld", instr_valid, 1);
    idle_step();
    chk("i1_op", opcode, 3'b010); chk("i1_a1", addr1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 12'd0);
      chk("stall_op", opcode, 3'b010);
      chk("stall_pc", pc, 2);
      chk("stall_vld", instr_valid, 1);
    end
    idle_step();
    chk("i2_op", opcode, 3'b011); chk("i2_a1", addr1, 3'd4);
    idle_step();
    chk("halt_vld", instr_valid, 0);
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 3);

    // Restart from HALT with a same-cycle write; a FETCH-time write must be dropped.
    step(1'b1, 1'b0, 1'b1, 4'd0, 12'b111010001000);
    chk("restart_halted", halted, 0);
    step(1'b0, 1'b0, 1'b1, 4'd2, 12'b000000000000);
    chk("r0_op", opcode, 3'b111); chk("r0_a1", addr1, 3'd2);
    chk("r0_a2", addr2, 3'd1);    chk("r0_a3", addr3, 3'd0);
    idle_step();
    idle_step();
    chk("gated_write_op", opcode, 3'b011);
    chk("gated_write_vld", instr_valid, 1);
    idle_step();
    chk("halt2_flag", halted, 1);

    // Wrap-around: all 16 words non-halt.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, i[3:0], 12'b101111101110);
    step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
    for (int k = 1; k <= 21; k++) begin
      idle_step();
      chk("wrap_vld", instr_valid, 1);
      chk("wrap_pc", pc, k % 16);
    end

    // Reset in FETCH at pc=5, away from the clock edge.
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_model();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b0, 4'd0, 12'd0);
    chk("post_rst_pc", pc, 0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
    idle_step();
    chk("mem_kept_op", opcode, 3'b101); chk("mem_kept_a1", addr1, 3'd7);
    chk("mem_kept_a2", addr2, 3'd5);    chk("mem_kept_a3", addr3, 3'd6);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rd = 12'($urandom);
      if ($urandom_range(0, 5) == 0) rd[11:9] = 3'b000;
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), 4'($urandom), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
